// File: rtl/preg_free_list_pkg.sv
// Shared core parameters and types for rename, ROB and the physical register free list.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package preg_free_list_pkg;

    localparam int NUM_PREGS = 64;
    localparam int NUM_AREGS = 32;
    localparam int PREG_W    = 6;
    localparam int FL_CNT_W  = 7;

    typedef logic [PREG_W-1:0]   preg_t;
    typedef logic [FL_CNT_W-1:0] fl_cnt_t;
    typedef logic [NUM_PREGS-1:0] preg_mask_t;

endpackage

// File: rtl/preg_free_list_if.sv
// Rename/retire-facing handshake bundle of the physical register free list.
// Latency: wires only.
// Backpressure: rename stalls while alloc_valid is low; releases are never stalled.
interface preg_free_list_if;
    import preg_free_list_pkg::*;

    logic    alloc_req;
    logic    alloc_valid;
    preg_t   alloc_preg;
    logic    rel_valid;
    preg_t   rel_preg;
    fl_cnt_t free_count;
    logic    err_double_free;

    // Rename/retire side drives requests and returns.
    modport master (
        output alloc_req, rel_valid, rel_preg,
        input  alloc_valid, alloc_preg, free_count, err_double_free
    );

    // Free list side.
    modport slave (
        input  alloc_req, rel_valid, rel_preg,
        output alloc_valid, alloc_preg, free_count, err_double_free
    );
endinterface

// File: rtl/preg_free_list_fl_ring.sv
// Circular FIFO of free physical register IDs with first-word fall-through head.
// Latency: a push becomes visible at the head no earlier than the next cycle.
// Backpressure: caller must not pop when empty; pushes never overflow (at most 63 IDs).
module fl_ring
    import preg_free_list_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    push_i,
    input  preg_t   push_dat_i,
    input  logic    pop_i,
    output preg_t   head_dat_o,
    output fl_cnt_t count_o
);

    preg_t   ring_q [NUM_PREGS];
    preg_t   head_q, head_d;
    preg_t   tail_q, tail_d;
    fl_cnt_t count_q, count_d;

    // Next pointers and occupancy; 6-bit pointers wrap 63->0 naturally.
    always_comb begin
        head_d  = pop_i  ? head_q + 6'd1 : head_q;
        tail_d  = push_i ? tail_q + 6'd1 : tail_q;
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 7'd1;
            2'b01:   count_d = count_q - 7'd1;
            default: count_d = count_q;
        endcase
    end

    // Ring storage and pointers; reset preloads p32..p63 as the initial free set.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                ring_q[i] <= preg_t'(i + NUM_AREGS);
            end
            head_q  <= '0;
            tail_q  <= preg_t'(NUM_AREGS);
            count_q <= fl_cnt_t'(NUM_PREGS - NUM_AREGS);
        end else begin
            if (push_i) begin
                ring_q[tail_q] <= push_dat_i;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_dat_o = ring_q[head_q];
    assign count_o    = count_q;

endmodule

// File: rtl/preg_free_list.sv
// Physical register free list: FIFO of free IDs plus a bitmap that screens out double frees.
// Latency: allocation/release take effect on the next edge; no same-cycle release bypass.
// Backpressure: alloc_req is ignored while alloc_valid is low; illegal releases are dropped.
module preg_free_list
    import preg_free_list_pkg::*;
(
    input logic              clk,
    input logic              rst,
    preg_free_list_if.slave  fl
);

    preg_mask_t is_free_q, is_free_d;
    logic       err_q, err_d;
    logic       alloc_fire;
    logic       rel_nonzero;
    logic       rel_accept;
    preg_t      head_preg;
    fl_cnt_t    count;

    assign fl.alloc_valid     = (count != '0);
    assign fl.alloc_preg      = head_preg;
    assign fl.free_count      = count;
    assign fl.err_double_free = err_q;

    // A release of p0 is discarded quietly; any other already-free ID is a double free.
    assign alloc_fire  = fl.alloc_req && fl.alloc_valid;
    assign rel_nonzero = fl.rel_valid && (fl.rel_preg != '0);
    assign rel_accept  = rel_nonzero && !is_free_q[fl.rel_preg];

    fl_ring u_ring (
        .clk        (clk),
        .rst        (rst),
        .push_i     (rel_accept),
        .push_dat_i (fl.rel_preg),
        .pop_i      (alloc_fire),
        .head_dat_o (head_preg),
        .count_o    (count)
    );

    // Bitmap update and error pulse; the head ID and an accepted release can never coincide.
    always_comb begin
        is_free_d = is_free_q;
        if (alloc_fire) begin
            is_free_d[head_preg] = 1'b0;
        end
        if (rel_accept) begin
            is_free_d[fl.rel_preg] = 1'b1;
        end
        err_d = rel_nonzero && is_free_q[fl.rel_preg];
    end

    // Registered bitmap and error flag; reset marks p32..p63 free, p0..p31 architecturally mapped.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_free_q <= {{(NUM_PREGS - NUM_AREGS){1'b1}}, {NUM_AREGS{1'b0}}};
            err_q     <= 1'b0;
        end else begin
            is_free_q <= is_free_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_preg_free_list.sv
// Directed bench for the physical register free list.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: exercises alloc on empty list and dropped releases.
module tb_preg_free_list;
    import preg_free_list_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    preg_free_list_if fl_if ();

    preg_free_list dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic rv, input int rp);
        fl_if.alloc_req = a;
        fl_if.rel_valid = rv;
        fl_if.rel_preg  = preg_t'(rp);
    endtask

    task automatic chk_post_reset(input string tag);
        chk({tag, "_valid"}, int'(fl_if.alloc_valid), 1);
        chk({tag, "_preg"},  int'(fl_if.alloc_preg), 32);
        chk({tag, "_count"}, int'(fl_if.free_count), 32);
        chk({tag, "_err"},   int'(fl_if.err_double_free), 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(1'b0, 1'b0, 0);
        tick();
        tick();
        rst = 1'b0;
        chk_post_reset("reset");

        // Double free of p40 (already free) then quiet drop of p0.
        drive(1'b0, 1'b1, 40);
        tick();
        drive(1'b0, 1'b0, 0);
        chk("dfree_err", int'(fl_if.err_double_free), 1);
        chk("dfree_count", int'(fl_if.free_count), 32);
        tick();
        chk("dfree_pulse_end", int'(fl_if.err_double_free), 0);
        drive(1'b0, 1'b1, 0);
        tick();
        drive(1'b0, 1'b0, 0);
        chk("p0_err", int'(fl_if.err_double_free), 0);
        chk("p0_count", int'(fl_if.free_count), 32);
        chk("p0_preg", int'(fl_if.alloc_preg), 32);

        // Release p5 while allocating p32: count unchanged, p5 queued behind p63.
        drive(1'b1, 1'b1, 5);
        tick();
        drive(1'b1, 1'b0, 0);
        chk("swap_count", int'(fl_if.free_count), 32);
        chk("swap_preg", int'(fl_if.alloc_preg), 33);
        chk("swap_err", int'(fl_if.err_double_free), 0);
        for (int i = 0; i < 31; i++) begin
            chk("swap_seq", int'(fl_if.alloc_preg), 33 + i);
            tick();
        end
        chk("swap_p5_preg", int'(fl_if.alloc_preg), 5);
        chk("swap_p5_count", int'(fl_if.free_count), 1);
        tick();
        chk("drain_valid", int'(fl_if.alloc_valid), 0);
        chk("drain_count", int'(fl_if.free_count), 0);

        // Empty list: alloc refused, same-cycle release of p7 not bypassed.
        drive(1'b1, 1'b1, 7);
        tick();
        drive(1'b0, 1'b0, 0);
        chk("empty_rel_valid", int'(fl_if.alloc_valid), 1);
        chk("empty_rel_preg", int'(fl_if.alloc_preg), 7);
        chk("empty_rel_count", int'(fl_if.free_count), 1);
        drive(1'b1, 1'b0, 0);
        tick();
        drive(1'b0, 1'b0, 0);
        chk("empty_rel_drain", int'(fl_if.free_count), 0);

        // Return p1..p31; tail crosses 63->0, FIFO order preserved.
        for (int i = 1; i <= 31; i++) begin
            drive(1'b0, 1'b1, i);
            tick();
        end
        drive(1'b0, 1'b0, 0);
        chk("wrap_count", int'(fl_if.free_count), 31);
        chk("wrap_err", int'(fl_if.err_double_free), 0);
        drive(1'b1, 1'b0, 0);
        for (int i = 1; i <= 31; i++) begin
            chk("wrap_seq", int'(fl_if.alloc_preg), i);
            tick();
        end
        drive(1'b0, 1'b0, 0);
        chk("wrap_drain_valid", int'(fl_if.alloc_valid), 0);
        chk("wrap_drain_count", int'(fl_if.free_count), 0);

        // Mid-stream reset with alloc and release asserted: reset wins.
        drive(1'b1, 1'b1, 3);
        tick();
        rst = 1'b1;
        drive(1'b1, 1'b1, 40);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 0);
        chk_post_reset("midrst");

        // Hold alloc for 32 cycles: p32..p63 in order, then empty.
        drive(1'b1, 1'b0, 0);
        for (int i = 0; i < 32; i++) begin
            chk("alloc32_seq", int'(fl_if.alloc_preg), 32 + i);
            tick();
        end
        drive(1'b0, 1'b0, 0);
        chk("alloc32_valid", int'(fl_if.alloc_valid), 0);
        chk("alloc32_count", int'(fl_if.free_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/preg_free_list.md
PREG_FREE_LIST -- requirements
Module: preg_free_list

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL: alloc_req  input  1  rename requests one physical register this cycle.
REQ-004 SHALL: alloc_valid  output  1  free list non-empty; alloc_preg is valid.
REQ-005 SHALL: alloc_preg  output  6  physical register ID at head of free list (first-word fall-through).
REQ-006 SHALL: rel_valid  input  1  retire stage returns one physical register (the retired instruction's old_dr).
REQ-007 SHALL: rel_preg  input  6  physical register ID being returned.
REQ-008 SHALL: free_count  output  7  number of IDs currently in the list, 0..63.
REQ-009 SHALL: err_double_free  output  1  one-cycle pulse flagging an illegal release.

Function
REQ-010 SHALL: hold free IDs in a 64-entry circular buffer with 6-bit head/tail pointers and a 7-bit count; pointers wrap 63->0.
REQ-011 SHALL: maintain a 64-bit is_free bitmap, bit n = 1 iff preg n is in the list.
REQ-012 SHALL: drive alloc_valid = (count != 0) and alloc_preg = buffer[head] combinationally from registered state.
REQ-013 SHALL: perform an allocation on a rising edge when alloc_req && alloc_valid: head+1, count-1, is_free[alloc_preg] cleared.
REQ-014 SHALL: ignore alloc_req when alloc_valid = 0; no state change (rename stalls on !alloc_valid).
REQ-015 SHALL: accept a release when rel_valid && rel_preg != 0 && !is_free[rel_preg]: buffer[tail] = rel_preg, tail+1, count+1, is_free[rel_preg] set.
REQ-016 SHALL: silently drop a release of preg 0 (x0 mapping is never recycled) with no error.
REQ-017 SHALL: drop a release of a preg whose is_free bit is already 1 and assert err_double_free in the next cycle for exactly one cycle.
REQ-018 SHALL: on simultaneous accepted allocation and release, update head and tail, leave count unchanged, and clear/set the respective is_free bits (same ID cannot occur, since a head ID is free and would be a double-free).
REQ-019 SHALL: never bypass a same-cycle release to alloc_preg; with count = 0, alloc is refused and the released ID becomes allocatable the following cycle.
REQ-020 SHALL: never exceed count 63 (preg 0 excluded, double-free blocked); no full output is required.
REQ-021 SHALL: have allocation-to-visibility latency of one cycle: alloc_preg shows the next head on the cycle after an allocation.

Reset
REQ-022 SHALL: on rst high at a rising edge, load buffer[i] = 32+i for i = 0..31, head = 0, tail = 32, count = 32.
REQ-023 SHALL: set is_free bits 32..63 = 1 and bits 0..31 = 0 on reset (arch regs x0..x31 map to p0..p31).
REQ-024 SHALL: give outputs after reset: alloc_valid = 1, alloc_preg = 32, free_count = 32, err_double_free = 0.
REQ-025 SHALL: let rst take priority over alloc_req and rel_valid in the same cycle; any in-flight request is discarded.

Structure
REQ-026 SHALL: place NUM_PREGS = 64, NUM_AREGS = 32, PREG_W = 6, FL_CNT_W = 7 in the shared core package used by rename and ROB.
REQ-027 SHALL: implement the storage/pointer logic as one sub-module fl_ring (push/pop ring buffer); bitmap and error checks live in preg_free_list.

Verification
REQ-028 SHALL: reset then alloc_req held 32 cycles -> alloc_preg 32,33,...,63 in order; alloc_valid = 0 and free_count = 0 after the 32nd.
REQ-029 SHALL: with count = 0, release preg 7 with alloc_req high in the same cycle -> no allocation that cycle; next cycle alloc_valid = 1, alloc_preg = 7, free_count = 1.
REQ-030 SHALL: from reset, release p5 while allocating -> free_count stays 32, alloc_preg becomes 33, p5 appears after p63 is allocated.
REQ-031 SHALL: release p40 directly after reset (already free) -> err_double_free high for one cycle, free_count stays 32; release p0 -> no error, no change.
REQ-032 SHALL: release 31 IDs (p1..p31) after draining the list -> free_count = 31, tail wraps past 63 to 0 correctly, allocations return p1..p31 in order.
REQ-033 SHALL: assert rst with alloc_req and rel_valid high mid-stream -> next cycle state equals post-reset values of REQ-024.
